// File: rtl/e_dec_conv.sv
// Converts a WORDS x 16-bit binary fraction to DIGITS decimal digits, MSD first.
// Each digit costs WORDS multiply-by-10 cycles plus one EMIT cycle held until digit_ready.
module e_dec_conv #(
  parameter int WORDS  = 32,
  parameter int DIGITS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] frac [0:WORDS-1],
  output logic        busy,
  output logic [3:0]  digit,
  output logic        digit_valid,
  input  logic        digit_ready,
  output logic [15:0] digit_idx,
  output logic        done
);

  localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WW-1:0] WLAST = WW'(WORDS - 1);
  localparam logic [15:0]   DLAST = 16'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, MUL, EMIT} state_t;

  state_t        state;
  logic [15:0]   buf_q [0:WORDS-1];
  logic [3:0]    carry;
  logic [WW-1:0] widx;
  logic [15:0]   dcnt;
  logic [19:0]   prod;

  // buf*10 + 9 < 10*2^16, so the top nibble is always a valid decimal carry
  assign prod = ({4'd0, buf_q[widx]} * 20'd10) + {16'd0, carry};
  assign digit_idx = dcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      for (int k = 0; k < WORDS; k++) buf_q[k] <= '0;
      carry       <= '0;
      widx        <= '0;
      dcnt        <= '0;
      busy        <= 1'b0;
      digit       <= '0;
      digit_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < WORDS; k++) buf_q[k] <= frac[k];
            carry <= '0;
            widx  <= '0;
            dcnt  <= '0;
            busy  <= 1'b1;
            state <= MUL;
          end
        end
        MUL: begin
          buf_q[widx] <= prod[15:0];
          if (widx == WLAST) begin
            digit       <= prod[19:16];
            carry       <= '0;
            widx        <= '0;
            digit_valid <= 1'b1;
            state       <= EMIT;
          end else begin
            carry <= prod[19:16];
            widx  <= widx + WW'(1);
          end
        end
        EMIT: begin
          if (digit_ready) begin
            digit_valid <= 1'b0;
            if (dcnt == DLAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              dcnt  <= dcnt + 16'd1;
              state <= MUL;
            end
          end
        end
        default: begin
          busy        <= 1'b0;
          digit_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e_dec_conv.sv
// Directed bench for e_dec_conv: two instances (8 and 100 digits) share clk, rst, frac and ready.
module tb_e_dec_conv;
  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, start100 = 1'b0;
  logic [15:0] frac [0:W-1];
  logic        digit_ready = 1'b1;

  logic        busy8, vld8, done8, busy100, vld100, done100;
  logic [3:0]  dig8, dig100;
  logic [15:0] idx8, idx100;

  e_dec_conv #(.WORDS(W), .DIGITS(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .frac(frac), .busy(busy8),
    .digit(dig8), .digit_valid(vld8), .digit_ready(digit_ready),
    .digit_idx(idx8), .done(done8));

  e_dec_conv #(.WORDS(W), .DIGITS(100)) u_dut100 (
    .clk(clk), .rst(rst), .start(start100), .frac(frac), .busy(busy100),
    .digit(dig100), .digit_valid(vld100), .digit_ready(digit_ready),
    .digit_idx(idx100), .done(done100));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int t0, first_vld, done_cyc;
  int exp_d [0:99];
  int got   [0:99];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // mode 0: zero, 1: 0.5, 2: 0.25, 3: all ones, 4: e-2 in the top 128 bits
  task automatic set_frac(input int mode);
    for (int k = 0; k < W; k++) frac[k] = (mode == 3) ? 16'hFFFF : 16'h0000;
    case (mode)
      1: frac[31] = 16'h8000;
      2: frac[31] = 16'h4000;
      4: begin
        frac[31] = 16'hB7E1; frac[30] = 16'h5162; frac[29] = 16'h8AED; frac[28] = 16'h2A6A;
        frac[27] = 16'hBF71; frac[26] = 16'h5880; frac[25] = 16'h9CF4; frac[24] = 16'hF3C7;
      end
      default: ;
    endcase
  endtask

  // Big-integer reference: repeatedly multiply the whole fraction by ten
  task automatic model(input int ndig);
    logic [16*W-1:0] v;
    logic [16*W+3:0] p;
    for (int k = 0; k < W; k++) v[16*k +: 16] = frac[k];
    for (int d = 0; d < ndig; d++) begin
      p = {4'd0, v} * 10;
      exp_d[d] = int'(p[16*W+3:16*W]);
      v = p[16*W-1:0];
    end
  endtask

  task automatic fill_exp(input int first, input int rest);
    for (int d = 0; d < 100; d++) exp_d[d] = (d == 0) ? first : rest;
  endtask

  task automatic start_conv(input int which, input bit hold);
    if (which == 0) start8 = 1'b1; else start100 = 1'b1;
    @(negedge clk);
    t0 = cyc;
    if (!hold) begin start8 = 1'b0; start100 = 1'b0; end
  endtask

  task automatic collect(input int which, input int ndig, input int stall_idx,
                         input int stall_len, input bit pulse);
    int k, stall, guard, c;
    logic m_vld, m_done, m_busy;
    logic [3:0] m_dig;
    logic [15:0] m_idx;
    k = 0; stall = 0; guard = 0;
    first_vld = -1; done_cyc = -1;
    digit_ready = 1'b1;
    while (done_cyc < 0 && guard < ndig * (W + 1) + 200) begin
      c = cyc - t0 + 1;
      m_vld  = which ? vld100  : vld8;
      m_done = which ? done100 : done8;
      m_busy = which ? busy100 : busy8;
      m_dig  = which ? dig100  : dig8;
      m_idx  = which ? idx100  : idx8;
      if (pulse) start8 = (c == 10 || c == W + 1);
      if (m_done) begin
        done_cyc = c;
        chk("digits_before_done", k, ndig);
        chk("busy_at_done", m_busy, 0);
      end else if (m_vld) begin
        if (first_vld < 0) first_vld = c;
        if (k == stall_idx && stall < stall_len) begin
          digit_ready = 1'b0;
          chk("stall_digit", m_dig, exp_d[k]);
          chk("stall_idx", m_idx, k);
          stall++;
        end else begin
          digit_ready = 1'b1;
          chk("digit_idx", m_idx, k);
          chk("digit", m_dig, exp_d[k]);
          if (k < 100) got[k] = int'(m_dig);
          k++;
        end
      end
      @(negedge clk);
      guard++;
    end
    start8 = 1'b0;
    digit_ready = 1'b1;
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    chk("done_one_cycle", which ? done100 : done8, 0);
  endtask

  initial begin
    int e_ref [0:14];
    int nd, nb;
    e_ref = '{7,1,8,2,8,1,8,2,8,4,5,9,0,4,5};
    set_frac(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_digit", dig8, 0);
    chk("rst_valid", vld8, 0);
    chk("rst_idx", idx8, 0);
    chk("rst_done", done8, 0);
    chk("rst_busy100", busy100, 0);
    rst = 1'b0;
    @(negedge clk);

    // 0.5 -> 5,0,0,...; latency checks
    set_frac(1); fill_exp(5, 0);
    start_conv(0, 0);
    chk("busy_cycle1", busy8, 1);
    collect(0, 8, -1, 0, 0);
    chk("first_valid_cycle", first_vld, 33);
    chk("done_cycle", done_cyc, 8 * 33 + 1);

    // 0.25 with a 10-cycle stall on digit 1
    set_frac(2); fill_exp(2, 0); exp_d[1] = 5;
    start_conv(0, 0);
    collect(0, 8, 1, 10, 0);
    chk("stall_done_cycle", done_cyc, 8 * 33 + 1 + 10);

    // start pulses during MUL and EMIT are ignored
    set_frac(1); fill_exp(5, 0);
    start_conv(0, 0);
    collect(0, 8, -1, 0, 1);
    chk("pulse_done_cycle", done_cyc, 8 * 33 + 1);

    // all ones -> 100 nines
    set_frac(3); fill_exp(9, 9);
    start_conv(1, 0);
    collect(1, 100, -1, 0, 0);
    chk("ones_done_cycle", done_cyc, 100 * 33 + 1);

    // e-2, against the big-integer model and the known leading digits
    set_frac(4); model(100);
    start_conv(1, 0);
    collect(1, 100, -1, 0, 0);
    for (int d = 0; d < 15; d++) chk($sformatf("e_digit%0d", d), got[d], e_ref[d]);

    // start held high through done: exactly one restart after IDLE
    set_frac(2); fill_exp(2, 0); exp_d[1] = 5;
    start_conv(0, 1);
    set_frac(1);
    collect(0, 8, -1, 0, 0);
    chk("held_start_restart", busy8, 1);
    t0 = cyc;
    start8 = 1'b0;
    fill_exp(5, 0);
    collect(0, 8, -1, 0, 0);
    chk("held_start_second_done", done_cyc, 8 * 33 + 1);
    chk("no_third_conv", busy8, 0);

    // reset mid-MUL of digit 3
    set_frac(1);
    start_conv(0, 0);
    while (cyc - t0 + 1 < 110) @(negedge clk);
    chk("busy_mid_mul", busy8, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_busy", busy8, 0);
    chk("rr_digit", dig8, 0);
    chk("rr_valid", vld8, 0);
    chk("rr_idx", idx8, 0);
    chk("rr_done", done8, 0);
    rst = 1'b0;
    nd = 0; nb = 0;
    repeat (300) begin
      @(negedge clk);
      if (done8) nd++;
      if (busy8) nb++;
    end
    chk("rr_no_done", nd, 0);
    chk("rr_stays_idle", nb, 0);
    fill_exp(5, 0);
    start_conv(0, 0);
    collect(0, 8, -1, 0, 0);
    chk("rr_fresh_done_cycle", done_cyc, 8 * 33 + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
